muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply-divide: radix-2 shift-add / restoring division, one bit per cycle.
// Result WIDTH+2 cycles after accept (divide-by-zero: 1 cycle); start is ignored while busy, no backpressure on results.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] high,
    output logic [WIDTH-1:0] low
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] low_q, low_d;

    logic               sgn_op;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_sum, rem_shift, rem_diff;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        dz_d     = dz_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        high_d   = high_q;
        low_d    = low_q;

        sgn_op    = ~op[0];
        mag_a     = (sgn_op && a[WIDTH-1]) ? -a : a;
        mag_b     = (sgn_op && b[WIDTH-1]) ? -b : b;
        add_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opnd_q};
        prod_fix  = (neg_a_q ^ neg_b_q) ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d    = '0;
                    is_div_d = op[1];
                    neg_a_d  = sgn_op & a[WIDTH-1];
                    neg_b_d  = sgn_op & b[WIDTH-1];
                    if (op[1] && (b == '0)) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        dz_d     = 1'b0;
                        state_d  = CALC;
                        // Mult: opnd is the addend, lo holds the multiplier being shifted out.
                        // Div: opnd is the divisor, lo holds the dividend shifting into the remainder.
                        opnd_d   = op[1] ? mag_b : mag_a;
                        acc_hi_d = '0;
                        acc_lo_d = op[1] ? mag_a : mag_b;
                    end
                end
            end
            CALC: begin
                if (is_div_q) begin
                    // rem_diff[WIDTH] is the borrow: set means the trial subtraction must be undone.
                    acc_hi_d = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
                end else begin
                    {acc_hi_d, acc_lo_d} = {add_sum, acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    low_d  = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
                    high_d = neg_a_q ? -acc_hi_q : acc_hi_q;
                end else begin
                    {high_d, low_d} = prod_fix;
                end
                state_d = DONE;
            end
            DONE: begin
                dz_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            high_q   <= '0;
            low_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dz_q     <= dz_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            high_q   <= high_d;
            low_q    <= low_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign div_zero = (state_q == DONE) && dz_q;
    assign high     = high_q;
    assign low      = low_q;

endmodule
